// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands CHUNK bits per clock behind valid/ready handshakes.
// Optional ADDSUB_MODE_EN adds a 'sub' port that turns the operation into a - b.
module chunk_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSUB_MODE_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("chunk_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [CHUNK-1:0]   a_chunk, b_chunk;
  logic [CHUNK:0]     res;
  logic [31:0]        sh;
  logic               msb_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, chunk datapath and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    sh      = 32'(idx_q) * CHUNK;
    a_chunk = CHUNK'(a_q >> sh);
    b_chunk = CHUNK'(b_q >> sh);
    res     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the operand MSB recovered from the MSB sum bit of the last chunk.
    msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ res[CHUNK-1];

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = a;
`ifdef ADDSUB_MODE_EN
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = (sum_q & ~(CMASK << sh)) | (WIDTH'(res[CHUNK-1:0]) << sh);
        carry_d = res[CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NCHUNK - 1)) begin
          cout_d  = res[CHUNK];
          ovf_d   = msb_cin ^ res[CHUNK];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed self-checking bench for chunk_serial_adder (WIDTH=16, CHUNK=4); define ADDSUB_MODE_EN to cover subtraction.
module tb_chunk_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout, overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef ADDSUB_MODE_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  typedef struct {
    string       name;
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic vs, input logic [15:0] es,
                         input logic eco, input logic eov);
    vec_t v;
    v.name = n; v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
    v.s = es; v.co = eco; v.ov = eov;
    vecs.push_back(v);
  endtask

  // Apply one operation from IDLE, check handshake, latency and results, then drain.
  task automatic run_vec(input vec_t v);
    int lat;
    chk({v.name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({v.name, ".in_ready_run"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, ".latency"}, 32'(lat), 32'd4);
    chk({v.name, ".sum"}, 32'(sum), 32'(v.s));
    chk({v.name, ".cout"}, 32'(cout), 32'(v.co));
    chk({v.name, ".overflow"}, 32'(overflow), 32'(v.ov));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.name, ".drain"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    vec_t v;
    int   lat;

    add_vec("add_small",   16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0);
    add_vec("ripple_all",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    add_vec("cin_only",    16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
    add_vec("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    add_vec("neg_ovf",     16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    add_vec("ripple_3",    16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    add_vec("all_ones",    16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    add_vec("mixed",       16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    add_vec("neg_ovf2",    16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`ifdef ADDSUB_MODE_EN
    add_vec("sub_5m3",     16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    add_vec("sub_cin_ign", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    add_vec("sub_3m5",     16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    add_vec("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    add_vec("sub0_add",    16'h0003, 16'h0005, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0);
`endif

    // Reset values while held in reset.
    #12;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.outs", {14'd0, out_valid, cout, overflow, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: result held while inputs churn.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.latency", 32'(lat), 32'd4);
    for (int c = 0; c < 6; c++) begin
      in_valid = ~in_valid;
      a = 16'(16'hA5A5 + c); b = 16'(16'h0F0F * (c + 1)); cin = ~cin;
      @(posedge clk); #1;
      chk("bp.hold_hs", {30'd0, out_valid, in_ready}, 32'b10);
      chk("bp.hold_res", {14'd0, cout, overflow, sum}, 32'h0000_5555);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.release", {30'd0, in_ready, out_valid}, 32'b10);

    // Leave cout/overflow set, then reset mid-RUN.
    v.name = "pre_rst"; v.a = 16'h8000; v.b = 16'h8000; v.cin = 1'b0; v.sub = 1'b0;
    v.s = 16'h0000; v.co = 1'b1; v.ov = 1'b1;
    run_vec(v);
    a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrun.partial", 32'(sum), 32'h0000_0022);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun.cleared", {14'd0, out_valid, cout, overflow, sum}, 32'd0);
    chk("midrun.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    v.name = "post_rst"; v.a = 16'h00FF; v.b = 16'h0001; v.cin = 1'b0; v.sub = 1'b0;
    v.s = 16'h0100; v.co = 1'b0; v.ov = 1'b0;
    run_vec(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
